blf_ctrl: RTL



---
 rtl/blf_ctrl_pkg.sv | 21 ++
 rtl/blf_ctrl_edge_det.sv | 25 ++
 rtl/blf_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/blf_ctrl_pkg.sv
// blf_ctrl shared definitions: FSM state encodings, reset rate code,
// auxiliary counter width and the abortable-state helper.
package blf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } blf_state_e;

    localparam logic [3:0] DR_RST = 4'b0011;
    localparam int         AUX_W  = 8;

    function automatic logic abortable(input blf_state_e s);
        return (s == ST_CFG) || (s == ST_SETTLE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/blf_ctrl_edge_det.sv
// blf_edge_det: one-stage register of DOUB_BLF plus a registered
// rising-edge pulse; the raw rise is also exported for same-cycle use.
module blf_edge_det (
    input  logic clk_1_92m,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic pulse
);

    logic d1;

    assign rise = din & ~d1;

    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            d1    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            d1    <= din;
            pulse <= rise;
        end
    end

endmodule

// File: rtl/blf_ctrl.sv
// blf_ctrl: sequences DIV per tag reply (rate load, settle, run, drain).
// Optional watchdog on RUN/DRAIN enabled with `define BLF_TIMEOUT_EN.
module blf_ctrl
    import blf_ctrl_pkg::*;
#(
    parameter int LEN_W       = 10,
    parameter int SETTLE_CYC  = 2,
    parameter int DRAIN_QUIET = 4
`ifdef BLF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic             clk_1_92m,
    input  logic             rst,
    input  logic [3:0]       dr_in,
    input  logic             dr_vld,
    input  logic             tx_req,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             tx_abort,
    input  logic             doub_blf,
    output logic             set_m,
    output logic [3:0]       DR,
    output logic             div_en,
    output logic             blf_tick,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);

    blf_state_e       state;
    blf_state_e       nxt;
    logic [3:0]       pend_dr;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] per_cnt;
    logic [AUX_W-1:0] aux_cnt;
    logic             rise;
    logic             abort_ok;
    logic             per_last;
    logic             settle_last;
    logic             quiet_last;
    logic             err_set;
    logic             tmo_run;
    logic             tmo_drain;

    blf_edge_det u_edge (
        .clk_1_92m (clk_1_92m),
        .rst       (rst),
        .din       (doub_blf),
        .rise      (rise),
        .pulse     (blf_tick)
    );

    assign abort_ok    = tx_abort && abortable(state);
    assign per_last    = rise && ((per_cnt + 1'b1) == len_q);
    assign settle_last = (aux_cnt == AUX_W'(SETTLE_CYC - 1));
    assign quiet_last  = !doub_blf &&
                         (aux_cnt == AUX_W'(DRAIN_QUIET - 1));

    assign set_m   = (state == ST_CFG);
    assign div_en  = (state == ST_RUN);
    assign tx_busy = (state != ST_IDLE);
    assign tx_done = (state == ST_DONE);

`ifdef BLF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_last;

    assign wd_last   = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign tmo_run   = (state == ST_RUN) && wd_last && !rise;
    assign tmo_drain = (state == ST_DRAIN) && wd_last;

    // Restarts on every state change and on each period in RUN.
    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (nxt != state) begin
            wd_cnt <= '0;
        end else if (state == ST_RUN && rise) begin
            wd_cnt <= '0;
        end else if (state == ST_RUN || state == ST_DRAIN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign tmo_run   = 1'b0;
    assign tmo_drain = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        err_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tx_req) begin
                    nxt = (tx_len == '0) ? ST_DONE : ST_CFG;
                end
            end
            ST_CFG: begin
                nxt     = abort_ok ? ST_DRAIN : ST_SETTLE;
                err_set = abort_ok;
            end
            ST_SETTLE: begin
                if (abort_ok) begin
                    nxt     = ST_DRAIN;
                    err_set = 1'b1;
                end else if (settle_last) begin
                    nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_ok) begin
                    nxt     = ST_DRAIN;
                    err_set = 1'b1;
                end else if (per_last) begin
                    nxt = ST_DRAIN;
                end else if (tmo_run) begin
                    nxt     = ST_DRAIN;
                    err_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (quiet_last) begin
                    nxt = ST_DONE;
                end else if (tmo_drain) begin
                    nxt     = ST_DONE;
                    err_set = 1'b1;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            state  <= ST_IDLE;
            tx_err <= 1'b0;
        end else begin
            state  <= nxt;
            tx_err <= err_set;
        end
    end

    // DR is loaded on entry to CFG so it is already stable while set_m
    // is high; a same-cycle dr_vld bypasses pend_dr.
    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            pend_dr <= DR_RST;
            DR      <= DR_RST;
            len_q   <= '0;
        end else begin
            if (dr_vld) begin
                pend_dr <= dr_in;
            end
            if (state == ST_IDLE && nxt == ST_CFG) begin
                len_q <= tx_len;
                DR    <= dr_vld ? dr_in : pend_dr;
            end
        end
    end

    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (state != ST_RUN) begin
            per_cnt <= '0;
        end else if (rise) begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Shared by SETTLE (cycle count) and DRAIN (consecutive-low count).
    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            aux_cnt <= '0;
        end else if (nxt != state) begin
            aux_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            aux_cnt <= aux_cnt + 1'b1;
        end else if (state == ST_DRAIN) begin
            aux_cnt <= doub_blf ? '0 : aux_cnt + 1'b1;
        end else begin
            aux_cnt <= '0;
        end
    end

endmodule
